// File: rtl/rv32_pkg.sv
// Shared definitions for the minimal RV32I core: widths, reset defaults, fetch FSM encoding.
package rv32_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned INSTRUCTION_WIDTH = 32;

    localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION  = 32'h0000_0013;
    localparam logic [XLEN-1:0]              RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        HOLD,
        DRAIN
    } fetch_state;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] address);
        return {address[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_rv32_if.sv
// Fetch-stage bus bundle: instruction-memory read port and the decode valid/ready handshake.
interface fetch_rv32_if;
    import rv32_pkg::*;

    logic [XLEN-1:0]              memory_read_address;
    logic                         read_enable;
    logic [INSTRUCTION_WIDTH-1:0] memory_read_value;
    logic                         memory_read_valid;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic [XLEN-1:0]              instruction_pc;
    logic                         instruction_valid;
    logic                         instruction_ready;

    modport master (
        output memory_read_address,
        output read_enable,
        input  memory_read_value,
        input  memory_read_valid,
        output instruction,
        output instruction_pc,
        output instruction_valid,
        input  instruction_ready
    );

    modport slave (
        input  memory_read_address,
        input  read_enable,
        output memory_read_value,
        output memory_read_valid,
        input  instruction,
        input  instruction_pc,
        input  instruction_valid,
        output instruction_ready
    );

endinterface

// File: rtl/fetch_pc_rv32.sv
// Program counter for the fetch stage: +4 advance, redirect override with word alignment.
module fetch_pc_rv32
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            advance,
    input  logic            redirect_enable,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next
);

    // Redirect wins over the sequential advance; addition wraps naturally at 2^XLEN.
    always_comb begin
        pc_next = pc;
        if (redirect_enable) begin
            pc_next = align_word(redirect_target);
        end else if (advance) begin
            pc_next = pc + XLEN'(4);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_rv32.sv
// RV32I fetch stage: single-outstanding instruction reads, decode handshake, redirect handling.
module fetch_rv32
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            redirect_enable,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc,
    fetch_rv32_if.master    bus
);

    fetch_state                   state;
    logic                         read_enable_q;
    logic [XLEN-1:0]              address_q;
    logic [INSTRUCTION_WIDTH-1:0] instruction_q;
    logic [XLEN-1:0]              instruction_pc_q;
    logic                         instruction_valid_q;

    logic [XLEN-1:0] pc_next;
    logic            advance;
    fetch_state      resume_state;

    assign advance      = (state == REQUEST) && bus.memory_read_valid && !redirect_enable;
    assign resume_state = enable ? REQUEST : IDLE;

    fetch_pc_rv32 #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock           (clock),
        .reset           (reset),
        .advance         (advance),
        .redirect_enable (redirect_enable),
        .redirect_target (redirect_target),
        .pc              (pc),
        .pc_next         (pc_next)
    );

    // Leaving HOLD/DRAIN or a wrong-path response re-enters REQUEST at pc_next, which already
    // reflects any redirect arriving in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            read_enable_q       <= 1'b0;
            address_q           <= RESET_PC;
            instruction_q       <= NOP_INSTRUCTION;
            instruction_pc_q    <= RESET_PC;
            instruction_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!redirect_enable && enable) begin
                        state         <= REQUEST;
                        read_enable_q <= 1'b1;
                        address_q     <= pc_next;
                    end
                end
                REQUEST: begin
                    if (redirect_enable && !bus.memory_read_valid) begin
                        state <= DRAIN;
                    end else if (redirect_enable) begin
                        state         <= resume_state;
                        read_enable_q <= enable;
                        address_q     <= pc_next;
                    end else if (bus.memory_read_valid) begin
                        state               <= HOLD;
                        read_enable_q       <= 1'b0;
                        instruction_q       <= bus.memory_read_value;
                        instruction_pc_q    <= address_q;
                        instruction_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_enable || bus.instruction_ready) begin
                        state               <= resume_state;
                        read_enable_q       <= enable;
                        address_q           <= pc_next;
                        instruction_q       <= NOP_INSTRUCTION;
                        instruction_valid_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!redirect_enable && bus.memory_read_valid) begin
                        state         <= resume_state;
                        read_enable_q <= enable;
                        address_q     <= pc_next;
                    end
                end
                default: begin
                    state         <= IDLE;
                    read_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.read_enable         = read_enable_q;
    assign bus.memory_read_address = address_q;
    assign bus.instruction         = instruction_q;
    assign bus.instruction_pc      = instruction_pc_q;
    assign bus.instruction_valid   = instruction_valid_q;

endmodule

// File: tb/tb_fetch_rv32.sv
// Bench for fetch_rv32: directed scenarios plus a randomized run against a program-flow model.
module tb_fetch_rv32;
    import rv32_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        redirect_enable = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc;

    fetch_rv32_if bus ();

    fetch_rv32 #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .redirect_enable (redirect_enable),
        .redirect_target (redirect_target),
        .pc              (pc),
        .bus             (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [logic [31:0]];
    int          mem_latency = 1;
    logic        rand_lat = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], a[31:16]} ^ 32'h1234_5679;
    endfunction

    // Memory model: responds mem_latency cycles after a request is first seen, one-cycle strobe.
    initial begin
        int cnt;
        int extra;
        cnt = 0;
        extra = 0;
        bus.memory_read_valid = 1'b0;
        bus.memory_read_value = '0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                bus.memory_read_valid = 1'b0;
                cnt = 0;
            end else if (bus.memory_read_valid) begin
                bus.memory_read_valid = 1'b0;
                cnt = bus.read_enable ? 1 : 0;
            end else if (bus.read_enable) begin
                if (cnt >= (rand_lat ? 1 + extra : mem_latency)) begin
                    bus.memory_read_valid = 1'b1;
                    bus.memory_read_value = mem_word(bus.memory_read_address);
                    cnt = 0;
                    extra = $urandom_range(0, 2);
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        redirect_enable = 1'b0;
        bus.instruction_ready = 1'b0;
        mem_latency = 1;
        rand_lat = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_ivalid(input int bound, input string name);
        int n;
        n = 0;
        while (bus.instruction_valid !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (bus.instruction_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s: instruction_valid not seen within %0d cycles", name, bound);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.read_enable !== 1'b0 || bus.instruction_valid !== 1'b0 || pc !== 32'h0 ||
            bus.memory_read_address !== 32'h0 || bus.instruction !== 32'h13 ||
            bus.instruction_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset: re=%b iv=%b pc=%h addr=%h ins=%h ipc=%h required 0 0 0 0 13 0",
                     bus.read_enable, bus.instruction_valid, pc, bus.memory_read_address,
                     bus.instruction, bus.instruction_pc);
        end
    endtask

    task automatic test_basic_fetch();
        mem[32'h0] = 32'h0050_0093;
        do_reset();
        enable = 1'b1;
        bus.instruction_ready = 1'b1;
        step();
        checks++;
        if (bus.read_enable !== 1'b1 || bus.memory_read_address !== 32'h0) begin
            failures++;
            $display("FAIL basic_req: re=%b addr=%h required 1 0", bus.read_enable,
                     bus.memory_read_address);
        end
        step();
        checks++;
        if (bus.memory_read_valid !== 1'b1 || bus.instruction_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_resp: mv=%b iv=%b required 1 0", bus.memory_read_valid,
                     bus.instruction_valid);
        end
        step();
        checks++;
        if (bus.instruction_valid !== 1'b1 || bus.instruction !== 32'h0050_0093 ||
            bus.instruction_pc !== 32'h0 || bus.read_enable !== 1'b0) begin
            failures++;
            $display("FAIL basic_deliver: iv=%b ins=%h ipc=%h re=%b required 1 00500093 0 0",
                     bus.instruction_valid, bus.instruction, bus.instruction_pc,
                     bus.read_enable);
        end
        step();
        checks++;
        if (bus.read_enable !== 1'b1 || bus.memory_read_address !== 32'h4 ||
            bus.instruction_valid !== 1'b0 || bus.instruction !== 32'h13) begin
            failures++;
            $display("FAIL basic_next: re=%b addr=%h iv=%b ins=%h required 1 4 0 13",
                     bus.read_enable, bus.memory_read_address, bus.instruction_valid,
                     bus.instruction);
        end
        step();
        step();
        checks++;
        if (bus.instruction_valid !== 1'b1 || bus.instruction_pc !== 32'h4) begin
            failures++;
            $display("FAIL basic_throughput: iv=%b ipc=%h required 1 4", bus.instruction_valid,
                     bus.instruction_pc);
        end
    endtask

    task automatic test_stall();
        mem[32'h0] = 32'h0020_8133;
        do_reset();
        enable = 1'b1;
        wait_ivalid(10, "stall_wait");
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.instruction_valid !== 1'b1 || bus.instruction !== 32'h0020_8133 ||
                bus.instruction_pc !== 32'h0 || bus.read_enable !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: iv=%b ins=%h ipc=%h re=%b required 1 00208133 0 0",
                         i, bus.instruction_valid, bus.instruction, bus.instruction_pc,
                         bus.read_enable);
            end
        end
        bus.instruction_ready = 1'b1;
        step();
        checks++;
        if (bus.instruction_valid !== 1'b0 || bus.read_enable !== 1'b1 ||
            bus.memory_read_address !== 32'h4) begin
            failures++;
            $display("FAIL stall_accept: iv=%b re=%b addr=%h required 0 1 4",
                     bus.instruction_valid, bus.read_enable, bus.memory_read_address);
        end
    endtask

    task automatic test_drain();
        int n;
        do_reset();
        redirect_enable = 1'b1;
        redirect_target = 32'h0000_0008;
        step();
        redirect_enable = 1'b0;
        checks++;
        if (pc !== 32'h8 || bus.read_enable !== 1'b0) begin
            failures++;
            $display("FAIL idle_redirect: pc=%h re=%b required 8 0", pc, bus.read_enable);
        end
        enable = 1'b1;
        bus.instruction_ready = 1'b1;
        mem_latency = 4;
        step();
        step();
        step();
        redirect_enable = 1'b1;
        redirect_target = 32'h0000_0103;
        step();
        redirect_enable = 1'b0;
        checks++;
        if (bus.read_enable !== 1'b1 || bus.memory_read_address !== 32'h8 || pc !== 32'h100) begin
            failures++;
            $display("FAIL drain_enter: re=%b addr=%h pc=%h required 1 8 100", bus.read_enable,
                     bus.memory_read_address, pc);
        end
        n = 0;
        while (bus.memory_read_address === 32'h8 && n < 12) begin
            step();
            n++;
            checks++;
            if (bus.instruction_valid !== 1'b0 || bus.read_enable !== 1'b1) begin
                failures++;
                $display("FAIL drain_discard: iv=%b re=%b required 0 1", bus.instruction_valid,
                         bus.read_enable);
            end
        end
        mem_latency = 1;
        checks++;
        if (bus.memory_read_address !== 32'h100) begin
            failures++;
            $display("FAIL drain_next_addr: addr=%h required 100", bus.memory_read_address);
        end
        wait_ivalid(10, "drain_wait");
        checks++;
        if (bus.instruction_pc !== 32'h100 || bus.instruction !== mem_word(32'h100)) begin
            failures++;
            $display("FAIL drain_deliver: ipc=%h ins=%h required 100 %h", bus.instruction_pc,
                     bus.instruction, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        enable = 1'b1;
        wait_ivalid(10, "rhold_wait");
        bus.instruction_ready = 1'b1;
        redirect_enable = 1'b1;
        redirect_target = 32'h0000_0040;
        step();
        redirect_enable = 1'b0;
        checks++;
        if (bus.instruction_valid !== 1'b0 || bus.read_enable !== 1'b1 ||
            bus.memory_read_address !== 32'h40 || bus.instruction !== 32'h13) begin
            failures++;
            $display("FAIL rhold: iv=%b re=%b addr=%h ins=%h required 0 1 40 13",
                     bus.instruction_valid, bus.read_enable, bus.memory_read_address,
                     bus.instruction);
        end
        wait_ivalid(10, "rhold_wait2");
        checks++;
        if (bus.instruction_pc !== 32'h40) begin
            failures++;
            $display("FAIL rhold_deliver: ipc=%h required 40", bus.instruction_pc);
        end
    endtask

    task automatic test_redirect_valid();
        int n;
        for (int en = 1; en >= 0; en--) begin
            do_reset();
            enable = 1'b1;
            bus.instruction_ready = 1'b1;
            n = 0;
            while (bus.memory_read_valid !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            redirect_enable = 1'b1;
            redirect_target = 32'h0000_0201;
            enable = en[0];
            step();
            redirect_enable = 1'b0;
            checks++;
            if (bus.instruction_valid !== 1'b0 || bus.read_enable !== en[0] || pc !== 32'h200 ||
                (en == 1 && bus.memory_read_address !== 32'h200)) begin
                failures++;
                $display("FAIL rvalid_en%0d: iv=%b re=%b pc=%h addr=%h required 0 %0d 200 200",
                         en, bus.instruction_valid, bus.read_enable, pc,
                         bus.memory_read_address, en);
            end
            if (en == 1) begin
                wait_ivalid(10, "rvalid_wait");
                checks++;
                if (bus.instruction_pc !== 32'h200) begin
                    failures++;
                    $display("FAIL rvalid_deliver: ipc=%h required 200", bus.instruction_pc);
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    step();
                    checks++;
                    if (bus.read_enable !== 1'b0 || bus.instruction_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL rvalid_idle: re=%b iv=%b required 0 0", bus.read_enable,
                                 bus.instruction_valid);
                    end
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_enable = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        step();
        redirect_enable = 1'b0;
        enable = 1'b1;
        wait_ivalid(10, "wrap_wait");
        checks++;
        if (bus.instruction_pc !== 32'hFFFF_FFFC || pc !== 32'h0 ||
            bus.instruction !== mem_word(32'hFFFF_FFFC)) begin
            failures++;
            $display("FAIL wrap: ipc=%h pc=%h ins=%h required fffffffc 0 %h", bus.instruction_pc,
                     pc, bus.instruction, mem_word(32'hFFFF_FFFC));
        end
        bus.instruction_ready = 1'b1;
        step();
        checks++;
        if (bus.read_enable !== 1'b1 || bus.memory_read_address !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next: re=%b addr=%h required 1 0", bus.read_enable,
                     bus.memory_read_address);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1;
        mem_latency = 3;
        step();
        step();
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.read_enable !== 1'b0 || bus.instruction_valid !== 1'b0 || pc !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: re=%b iv=%b pc=%h required 0 0 0", bus.read_enable,
                     bus.instruction_valid, pc);
        end
        enable = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (bus.read_enable !== 1'b0) begin
                failures++;
                $display("FAIL disabled%0d: re=%b required 0", i, bus.read_enable);
            end
        end
    endtask

    // Program-flow model: the only instruction ever presented is the next one on the current path.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] p_addr;
        logic        p_re;
        logic        p_mv;
        logic        p_en;
        int          delivered;
        do_reset();
        rand_lat = 1'b1;
        exp_pc = 32'h0;
        p_re = 1'b0;
        p_mv = 1'b0;
        p_en = 1'b0;
        p_addr = '0;
        delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (bus.instruction_valid === 1'b1) begin
                checks++;
                if (bus.instruction_pc !== exp_pc ||
                    bus.instruction !== mem_word(bus.instruction_pc)) begin
                    failures++;
                    $display("FAIL rand_deliver@%0d: ipc=%h ins=%h required %h %h", cyc,
                             bus.instruction_pc, bus.instruction, exp_pc, mem_word(exp_pc));
                end
            end
            if (p_re && !p_mv) begin
                checks++;
                if (bus.read_enable !== 1'b1 || bus.memory_read_address !== p_addr) begin
                    failures++;
                    $display("FAIL rand_hold_req@%0d: re=%b addr=%h required 1 %h", cyc,
                             bus.read_enable, bus.memory_read_address, p_addr);
                end
            end
            if (!p_re && !p_en) begin
                checks++;
                if (bus.read_enable !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_enable@%0d: re=%b required 0", cyc, bus.read_enable);
                end
            end
            enable = ($urandom_range(0, 9) < 8);
            bus.instruction_ready = ($urandom_range(0, 9) < 7);
            redirect_enable = ($urandom_range(0, 19) == 0);
            redirect_target = $urandom;
            if (redirect_enable) begin
                exp_pc = {redirect_target[31:2], 2'b00};
            end else if (bus.instruction_valid && bus.instruction_ready) begin
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            p_re = bus.read_enable;
            p_mv = bus.memory_read_valid;
            p_addr = bus.memory_read_address;
            p_en = enable;
            step();
        end
        redirect_enable = 1'b0;
        checks++;
        if (delivered < 100) begin
            failures++;
            $display("FAIL rand_progress: delivered=%0d required >=100", delivered);
        end
    endtask

    initial begin
        bus.instruction_ready = 1'b0;
        test_reset();
        test_basic_fetch();
        test_stall();
        test_drain();
        test_redirect_hold();
        test_redirect_valid();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
